aha_clock_seq_controller: RTL and testbench
===========================================

AHA_CLOCK_SEQ_CONTROLLER -- requirements
Module: aha_clock_seq_controller

Interface
REQ-001 Parameter GATE_WAIT, default 4, cycles design clocks stay gated before master select changes; legal range 1..255.
REQ-002 Parameter SWITCH_WAIT, default 8, cycles after master select change before divider select changes; legal range 1..255.
REQ-003 Parameter DIV_WAIT, default 64, cycles after divider select change before clocks are re-enabled; legal range 1..255.
REQ-004 CLK  input  1  always-on reference clock; all logic is on its rising edge.
REQ-005 RESETn  input  1  asynchronous active-low reset.
REQ-006 REQ_VALID  input  1  reconfiguration request valid.
REQ-007 REQ_READY  output  1  controller can accept a request.
REQ-008 REQ_MASTER_SEL  input  1  target master clock select (0 = MASTER_CLK_0, 1 = MASTER_CLK_1).
REQ-009 REQ_DIV_SEL  input  3  target divider select (0..5 = by 1..by 32).
REQ-010 REQ_DOM_EN  input  2  target enable mask for design domains 0 and 1.
REQ-011 MASTER_CLK_SELECT  output  1  registered drive to the master clock switch.
REQ-012 DESIGN_CLK_SELECT  output  3  registered drive to both domain clock selectors.
REQ-013 DOM_CLK_EN  output  2  registered clock-gate enables, bit n for domain n.
REQ-014 BUSY  output  1  high whenever the state is not IDLE.
REQ-015 DONE  output  1  one-cycle pulse when a request completes.
REQ-016 ERR  output  1  one-cycle pulse when a request is rejected.

Function
REQ-017 States SHALL be IDLE, GATE, WAIT_GATE, WAIT_SWITCH, WAIT_DIV, FINISH; REQ_READY = (state == IDLE).
REQ-018 A request is accepted on cycle T when REQ_VALID && REQ_READY; the targets are latched at T, and later input changes have no effect.
REQ-019 Reject: if REQ_DIV_SEL > 5, ERR pulses at T+1, the state stays IDLE, and all outputs are unchanged.
REQ-020 Enable-only: if the targets equal the current MASTER_CLK_SELECT and DESIGN_CLK_SELECT, DOM_CLK_EN takes REQ_DOM_EN at T+1, DONE pulses at T+1, and the state stays IDLE.
REQ-021 Full sequence otherwise:
- DOM_CLK_EN = 2'b00 from T+1.
- MASTER_CLK_SELECT updates at T+1+GATE_WAIT.
- DESIGN_CLK_SELECT updates at T+1+GATE_WAIT+SWITCH_WAIT.
- DOM_CLK_EN takes the target mask, with a DONE pulse, at T+1+GATE_WAIT+SWITCH_WAIT+DIV_WAIT (FINISH).
- REQ_READY returns on the following cycle.
REQ-022 All phases SHALL run even if only one of the two selects changes; MASTER_CLK_SELECT is rewritten with its own value when unchanged.
REQ-023 The wait counter SHALL be 8 bits and loaded with the phase parameter on phase entry; the phase exits on the cycle the counter would decrement past 1, with no wrap.
REQ-024 DOM_CLK_EN SHALL never be nonzero while MASTER_CLK_SELECT or DESIGN_CLK_SELECT differs from its value at the most recent FINISH or enable-only completion.
REQ-025 DONE and ERR SHALL never be asserted in the same cycle, and never while in WAIT_* states.
REQ-026 REQ_VALID held high through FINISH SHALL be accepted again only at the first cycle REQ_READY is high, not in FINISH.

Reset
REQ-027 On RESETn low (asynchronous), outputs SHALL immediately take: MASTER_CLK_SELECT=0, DESIGN_CLK_SELECT=0, DOM_CLK_EN=2'b00, DONE=0, ERR=0, BUSY=0, REQ_READY=1; state=IDLE; counter=0.
REQ-028 Reset mid-sequence SHALL abandon the request with no DONE; the deassertion of RESETn is synchronized externally.

Structure
REQ-029 The state encoding, the divider-select limit constant (5), and the default wait values SHALL live in a shared package, aha_clock_pkg.
REQ-030 One sub-module is natural: aha_clock_seq_timer, an 8-bit loadable down-counter with a done flag; no other hierarchy.

Verification
REQ-031 Reset then idle: RESETn low mid-cycle -> outputs take their reset values asynchronously; REQ_READY=1 on the first edge after release.
REQ-032 Full switch with defaults: accept at T with MASTER=1, DIV=3, EN=2'b11:
- DOM_CLK_EN=0 at T+1.
- MASTER_CLK_SELECT=1 at T+5.
- DESIGN_CLK_SELECT=3 at T+13.
- DOM_CLK_EN=2'b11 and DONE at T+77.
- REQ_READY=1 at T+78.
REQ-033 Enable-only: from state MASTER=1, DIV=3, request the same selects with EN=2'b01 -> DOM_CLK_EN=2'b01 and DONE at T+1; BUSY stays 0.
REQ-034 Reject: REQ_DIV_SEL=6 -> ERR at T+1; outputs unchanged; REQ_READY stays 1.
REQ-035 Reset at T+10 of a full switch -> all outputs at reset values; no DONE pulse; next request accepted normally.
REQ-036 Back-to-back: REQ_VALID held high with new targets -> second acceptance only at T+78; no overlap of phases; DOM_CLK_EN=0 throughout the changes of both selects.

Source files
------------

// File: rtl/aha_clock_pkg.sv
// rtl/aha_clock_pkg.sv - shared definitions for the clock sequencing controller
// Purpose: controller state encoding, divider-select limit and default phase waits.
// Ports: none (package).
package aha_clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_GATE        = 3'd1,
    ST_WAIT_GATE   = 3'd2,
    ST_WAIT_SWITCH = 3'd3,
    ST_WAIT_DIV    = 3'd4,
    ST_FINISH      = 3'd5
  } state_t;

  // Highest legal divider select: 0..5 map to divide-by 1..32.
  localparam logic [2:0] DIV_SEL_MAX = 3'd5;

  localparam int unsigned GATE_WAIT_DEF   = 4;
  localparam int unsigned SWITCH_WAIT_DEF = 8;
  localparam int unsigned DIV_WAIT_DEF    = 64;

  function automatic logic div_sel_legal(input logic [2:0] sel);
    return sel <= DIV_SEL_MAX;
  endfunction

endpackage

// File: rtl/aha_clock_seq_timer.sv
// rtl/aha_clock_seq_timer.sv - 8-bit loadable down-counter with done flag
// Purpose: times each phase of the clock switch sequence.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - load load_value into the counter (wins over dec)
//   load_value  - phase length in cycles
//   dec         - decrement by one; holds at 1, never wraps
//   done        - counter has reached its last cycle (count <= 1)
module aha_clock_seq_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       dec,
  output logic       done
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && count > 8'd1) begin
      count <= count - 8'd1;
    end
  end

  // A phase of N cycles ends on the cycle the counter shows 1.
  assign done = (count <= 8'd1);

endmodule

// File: rtl/aha_clock_seq_controller.sv
// rtl/aha_clock_seq_controller.sv - glitch-safe master/divider clock switch sequencer
// Purpose: accepts reconfiguration requests, gates the design clocks, switches the
//   master select, then the divider select, then re-enables the requested domains.
// Ports:
//   CLK, RESETn        - reference clock, asynchronous active-low reset
//   REQ_VALID/READY    - request handshake
//   REQ_MASTER_SEL     - target master clock select
//   REQ_DIV_SEL        - target divider select (0..5)
//   REQ_DOM_EN         - target domain enable mask
//   MASTER_CLK_SELECT  - registered master clock switch drive
//   DESIGN_CLK_SELECT  - registered divider select drive
//   DOM_CLK_EN         - registered domain clock-gate enables
//   BUSY, DONE, ERR    - status: not idle, completion pulse, reject pulse
module aha_clock_seq_controller
  import aha_clock_pkg::*;
#(
  parameter int unsigned GATE_WAIT   = GATE_WAIT_DEF,
  parameter int unsigned SWITCH_WAIT = SWITCH_WAIT_DEF,
  parameter int unsigned DIV_WAIT    = DIV_WAIT_DEF
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_MASTER_SEL,
  input  logic [2:0] REQ_DIV_SEL,
  input  logic [1:0] REQ_DOM_EN,
  output logic       MASTER_CLK_SELECT,
  output logic [2:0] DESIGN_CLK_SELECT,
  output logic [1:0] DOM_CLK_EN,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam logic [7:0] GATE_W8   = 8'(GATE_WAIT);
  localparam logic [7:0] SWITCH_W8 = 8'(SWITCH_WAIT);
  localparam logic [7:0] DIV_W8    = 8'(DIV_WAIT);

  state_t     state, state_nxt;
  logic       tgt_master;
  logic [2:0] tgt_div;
  logic [1:0] tgt_en;

  logic       tmr_load, tmr_dec, tmr_done;
  logic [7:0] tmr_value;

  logic       accept, req_bad, req_same, latch_tgt;
  logic       master_nxt, done_nxt, err_nxt;
  logic [2:0] design_nxt;
  logic [1:0] en_nxt;

  assign REQ_READY = (state == ST_IDLE);
  assign BUSY      = (state != ST_IDLE);
  assign accept    = REQ_VALID && REQ_READY;
  assign req_bad   = !div_sel_legal(REQ_DIV_SEL);
  assign req_same  = (REQ_MASTER_SEL == MASTER_CLK_SELECT) && (REQ_DIV_SEL == DESIGN_CLK_SELECT);

  aha_clock_seq_timer u_timer (
    .clk        (CLK),
    .rst_n      (RESETn),
    .load       (tmr_load),
    .load_value (tmr_value),
    .dec        (tmr_dec),
    .done       (tmr_done)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:        if (accept && !req_bad && !req_same) state_nxt = ST_GATE;
      ST_GATE,
      ST_WAIT_GATE:   state_nxt = tmr_done ? ST_WAIT_SWITCH : ST_WAIT_GATE;
      ST_WAIT_SWITCH: if (tmr_done) state_nxt = ST_WAIT_DIV;
      ST_WAIT_DIV:    if (tmr_done) state_nxt = ST_FINISH;
      ST_FINISH:      state_nxt = ST_IDLE;
      default:        state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; each select is written on the
  // last cycle of the phase before it so it becomes visible on phase entry.
  always_comb begin
    tmr_load   = 1'b0;
    tmr_value  = 8'd0;
    tmr_dec    = 1'b0;
    latch_tgt  = 1'b0;
    master_nxt = MASTER_CLK_SELECT;
    design_nxt = DESIGN_CLK_SELECT;
    en_nxt     = DOM_CLK_EN;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_bad) begin
            err_nxt = 1'b1;
          end else if (req_same) begin
            en_nxt   = REQ_DOM_EN;
            done_nxt = 1'b1;
          end else begin
            latch_tgt = 1'b1;
            en_nxt    = 2'b00;
            tmr_load  = 1'b1;
            tmr_value = GATE_W8;
          end
        end
      end
      ST_GATE, ST_WAIT_GATE: begin
        if (tmr_done) begin
          master_nxt = tgt_master;
          tmr_load   = 1'b1;
          tmr_value  = SWITCH_W8;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_WAIT_SWITCH: begin
        if (tmr_done) begin
          design_nxt = tgt_div;
          tmr_load   = 1'b1;
          tmr_value  = DIV_W8;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_WAIT_DIV: begin
        if (tmr_done) begin
          en_nxt   = tgt_en;
          done_nxt = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      MASTER_CLK_SELECT <= 1'b0;
      DESIGN_CLK_SELECT <= 3'd0;
      DOM_CLK_EN        <= 2'b00;
      DONE              <= 1'b0;
      ERR               <= 1'b0;
      tgt_master        <= 1'b0;
      tgt_div           <= 3'd0;
      tgt_en            <= 2'b00;
    end else begin
      MASTER_CLK_SELECT <= master_nxt;
      DESIGN_CLK_SELECT <= design_nxt;
      DOM_CLK_EN        <= en_nxt;
      DONE              <= done_nxt;
      ERR               <= err_nxt;
      if (latch_tgt) begin
        tgt_master <= REQ_MASTER_SEL;
        tgt_div    <= REQ_DIV_SEL;
        tgt_en     <= REQ_DOM_EN;
      end
    end
  end

endmodule

// File: tb/tb_aha_clock_seq_controller.sv
// tb/tb_aha_clock_seq_controller.sv - directed self-checking bench for aha_clock_seq_controller
module tb_aha_clock_seq_controller;

  logic       CLK = 1'b0;
  logic       RESETn = 1'b1;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic       REQ_MASTER_SEL = 1'b0;
  logic [2:0] REQ_DIV_SEL = 3'd0;
  logic [1:0] REQ_DOM_EN = 2'b00;
  logic       MASTER_CLK_SELECT;
  logic [2:0] DESIGN_CLK_SELECT;
  logic [1:0] DOM_CLK_EN;
  logic       BUSY, DONE, ERR;

  int checks = 0;
  int errors = 0;

  aha_clock_seq_controller dut (
    .CLK               (CLK),
    .RESETn            (RESETn),
    .REQ_VALID         (REQ_VALID),
    .REQ_READY         (REQ_READY),
    .REQ_MASTER_SEL    (REQ_MASTER_SEL),
    .REQ_DIV_SEL       (REQ_DIV_SEL),
    .REQ_DOM_EN        (REQ_DOM_EN),
    .MASTER_CLK_SELECT (MASTER_CLK_SELECT),
    .DESIGN_CLK_SELECT (DESIGN_CLK_SELECT),
    .DOM_CLK_EN        (DOM_CLK_EN),
    .BUSY              (BUSY),
    .DONE              (DONE),
    .ERR               (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_master"}, 8'(MASTER_CLK_SELECT), 8'd0);
    chk({tag, "_design"}, 8'(DESIGN_CLK_SELECT), 8'd0);
    chk({tag, "_en"},     8'(DOM_CLK_EN),        8'd0);
    chk({tag, "_done"},   8'(DONE),              8'd0);
    chk({tag, "_err"},    8'(ERR),               8'd0);
    chk({tag, "_busy"},   8'(BUSY),              8'd0);
    chk({tag, "_ready"},  8'(REQ_READY),         8'd1);
  endtask

  // Called in acceptance cycle T (request already driven); returns in T+77.
  task automatic full_seq(input logic old_m, input logic [2:0] old_d,
                          input logic m, input logic [2:0] d, input logic [1:0] e,
                          input logic hold);
    tick();
    chk("t1_en", 8'(DOM_CLK_EN), 8'd0);
    chk("t1_busy", 8'(BUSY), 8'd1);
    chk("t1_ready", 8'(REQ_READY), 8'd0);
    chk("t1_master", 8'(MASTER_CLK_SELECT), 8'(old_m));
    if (!hold) begin
      // Targets were latched at T; later input changes must not matter.
      REQ_VALID      = 1'b0;
      REQ_MASTER_SEL = ~m;
      REQ_DIV_SEL    = d ^ 3'd1;
      REQ_DOM_EN     = ~e;
    end
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("gate_master", 8'(MASTER_CLK_SELECT), 8'(old_m));
      chk("gate_en", 8'(DOM_CLK_EN), 8'd0);
    end
    tick();
    chk("t5_master", 8'(MASTER_CLK_SELECT), 8'(m));
    chk("t5_design", 8'(DESIGN_CLK_SELECT), 8'(old_d));
    chk("t5_en", 8'(DOM_CLK_EN), 8'd0);
    for (int c = 6; c <= 12; c++) begin
      tick();
      chk("sw_design", 8'(DESIGN_CLK_SELECT), 8'(old_d));
      chk("sw_done", 8'(DONE), 8'd0);
      chk("sw_en", 8'(DOM_CLK_EN), 8'd0);
    end
    tick();
    chk("t13_design", 8'(DESIGN_CLK_SELECT), 8'(d));
    chk("t13_en", 8'(DOM_CLK_EN), 8'd0);
    for (int c = 14; c <= 76; c++) begin
      tick();
      chk("div_en", 8'(DOM_CLK_EN), 8'd0);
      chk("div_done", 8'(DONE), 8'd0);
      chk("div_err", 8'(ERR), 8'd0);
    end
    tick();
    chk("t77_en", 8'(DOM_CLK_EN), 8'(e));
    chk("t77_done", 8'(DONE), 8'd1);
    chk("t77_ready", 8'(REQ_READY), 8'd0);
    chk("t77_busy", 8'(BUSY), 8'd1);
    chk("t77_master", 8'(MASTER_CLK_SELECT), 8'(m));
    chk("t77_design", 8'(DESIGN_CLK_SELECT), 8'(d));
  endtask

  initial begin
    // Reset asserted between edges must take effect without a clock.
    #2 RESETn = 1'b0;
    #1 chk_reset_values("rst_async");
    @(posedge CLK);
    #4 RESETn = 1'b1;
    tick();
    chk("rel_ready", 8'(REQ_READY), 8'd1);
    chk("rel_busy", 8'(BUSY), 8'd0);

    // Full switch with default waits.
    REQ_VALID = 1'b1; REQ_MASTER_SEL = 1'b1; REQ_DIV_SEL = 3'd3; REQ_DOM_EN = 2'b11;
    full_seq(1'b0, 3'd0, 1'b1, 3'd3, 2'b11, 1'b0);
    tick();
    chk("t78_ready", 8'(REQ_READY), 8'd1);
    chk("t78_done", 8'(DONE), 8'd0);
    chk("t78_busy", 8'(BUSY), 8'd0);
    chk("t78_en", 8'(DOM_CLK_EN), 8'd3);

    // Enable-only request.
    REQ_VALID = 1'b1; REQ_MASTER_SEL = 1'b1; REQ_DIV_SEL = 3'd3; REQ_DOM_EN = 2'b01;
    tick();
    chk("eo_en", 8'(DOM_CLK_EN), 8'd1);
    chk("eo_done", 8'(DONE), 8'd1);
    chk("eo_busy", 8'(BUSY), 8'd0);
    chk("eo_ready", 8'(REQ_READY), 8'd1);
    chk("eo_master", 8'(MASTER_CLK_SELECT), 8'd1);
    REQ_VALID = 1'b0;
    tick();
    chk("eo_done_clr", 8'(DONE), 8'd0);
    chk("eo_en_hold", 8'(DOM_CLK_EN), 8'd1);

    // Illegal divider select is rejected.
    REQ_VALID = 1'b1; REQ_MASTER_SEL = 1'b0; REQ_DIV_SEL = 3'd6; REQ_DOM_EN = 2'b10;
    tick();
    chk("rej_err", 8'(ERR), 8'd1);
    chk("rej_done", 8'(DONE), 8'd0);
    chk("rej_master", 8'(MASTER_CLK_SELECT), 8'd1);
    chk("rej_design", 8'(DESIGN_CLK_SELECT), 8'd3);
    chk("rej_en", 8'(DOM_CLK_EN), 8'd1);
    chk("rej_ready", 8'(REQ_READY), 8'd1);
    chk("rej_busy", 8'(BUSY), 8'd0);
    REQ_VALID = 1'b0;
    tick();
    chk("rej_err_clr", 8'(ERR), 8'd0);

    // Reset at T+10 of a full switch abandons the request.
    REQ_VALID = 1'b1; REQ_MASTER_SEL = 1'b0; REQ_DIV_SEL = 3'd5; REQ_DOM_EN = 2'b10;
    tick();
    chk("ab_busy", 8'(BUSY), 8'd1);
    REQ_VALID = 1'b0;
    repeat (9) tick();
    chk("ab_t10_design", 8'(DESIGN_CLK_SELECT), 8'd3);
    #2 RESETn = 1'b0;
    #1 chk_reset_values("rst_mid");
    @(posedge CLK);
    #4 RESETn = 1'b1;
    tick();
    chk_reset_values("rst_after");
    tick();
    chk("rst_nodone", 8'(DONE), 8'd0);

    // Back-to-back: first request held valid through completion.
    REQ_VALID = 1'b1; REQ_MASTER_SEL = 1'b1; REQ_DIV_SEL = 3'd2; REQ_DOM_EN = 2'b01;
    full_seq(1'b0, 3'd0, 1'b1, 3'd2, 2'b01, 1'b1);
    // New targets presented during FINISH must wait for IDLE.
    REQ_MASTER_SEL = 1'b0; REQ_DIV_SEL = 3'd4; REQ_DOM_EN = 2'b10;
    tick();
    chk("b2b_ready", 8'(REQ_READY), 8'd1);
    chk("b2b_done_clr", 8'(DONE), 8'd0);
    chk("b2b_en", 8'(DOM_CLK_EN), 8'd1);
    full_seq(1'b1, 3'd2, 1'b0, 3'd4, 2'b10, 1'b0);
    tick();
    chk("b2b_end_ready", 8'(REQ_READY), 8'd1);
    chk("b2b_end_en", 8'(DOM_CLK_EN), 8'd2);
    chk("b2b_end_busy", 8'(BUSY), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
